platform_pll_reset_seq: RTL and testbench
=========================================

PLATFORM_PLL_RESET_SEQ -- requirements
Module: platform_pll_reset_seq

Interface
REQ-001 The block SHALL have parameter RST_PULSE_CYCLES, default 16, giving the PLL reset pulse length in clk cycles (range 1..255).
REQ-002 The block SHALL have parameter LOCK_FILTER_CYCLES, default 64, giving the consecutive synchronized-lock cycles required before release (range 1..1023).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, giving the maximum wait for lock per attempt (range 2..2^20).
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, giving the number of failed lock attempts before FAIL (range 1..15).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, free-running board reference clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port pll_locked, input, 1 bit: PLL locked output, asynchronous to clk.
REQ-008 The block SHALL have port soft_reset_req, input, 1 bit: single-cycle software request to restart the sequence.
REQ-009 The block SHALL have port pll_rst, output, 1 bit: active-high PLL reset.
REQ-010 The block SHALL have port sys_reset_n, output, 1 bit: active-low reset for the PLL-clocked system.
REQ-011 The block SHALL have port seq_state, output, 3 bits: current state encoding.
REQ-012 The block SHALL have port fail, output, 1 bit: lock could not be achieved.
REQ-013 The block SHALL have port loss_count, output, 8 bits: saturating count of lock losses while in RUN.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer; all decisions SHALL use locked_s, the synchronized value.
REQ-015 The FSM SHALL have states ASSERT_RST=0, WAIT_LOCK=1, FILTER=2, RUN=3, FAIL=4; all outputs SHALL be registered.
REQ-016 In ASSERT_RST, pll_rst=1 and sys_reset_n=0; after exactly RST_PULSE_CYCLES cycles in this state the FSM SHALL go to WAIT_LOCK and clear the timer.
REQ-017 In WAIT_LOCK, pll_rst=0; locked_s=1 SHALL move the FSM to FILTER with the filter counter cleared.
REQ-018 In WAIT_LOCK, the timer reaching LOCK_TIMEOUT_CYCLES-1 with locked_s=0 SHALL increment retry_cnt; if the new value equals MAX_RETRIES the FSM SHALL go to FAIL, else to ASSERT_RST.
REQ-019 In FILTER, locked_s=0 SHALL return the FSM to WAIT_LOCK with the timer restarted; LOCK_FILTER_CYCLES consecutive locked_s=1 cycles SHALL move it to RUN.
REQ-020 In RUN, sys_reset_n SHALL be 1, starting on the first RUN cycle, and retry_cnt SHALL be cleared.
REQ-021 In RUN, locked_s=0 SHALL drive sys_reset_n=0 on the next edge, increment loss_count (saturating at 255), and move the FSM to ASSERT_RST.
REQ-022 In FAIL, pll_rst=0, sys_reset_n=0 and fail=1; the FSM SHALL leave FAIL only on soft_reset_req or reset_n.
REQ-023 soft_reset_req=1 in any state SHALL move the FSM to ASSERT_RST with the pulse counter and retry_cnt cleared and fail cleared; it SHALL take priority over every simultaneous lock or timeout event. In ASSERT_RST it SHALL restart the pulse count.
REQ-024 fail SHALL be 0 in every state except FAIL.
REQ-025 Counters SHALL be sized with $clog2 of their parameter and SHALL NOT wrap.

Reset
REQ-026 While reset_n=0, the block SHALL force state=ASSERT_RST, pll_rst=1, sys_reset_n=0, fail=0, loss_count=0, retry_cnt=0, all counters=0 and synchronizer flops=0, asynchronously.
REQ-027 Assertion of reset_n mid-sequence SHALL abort the sequence immediately; after deassertion the full sequence SHALL restart from ASSERT_RST.

Structure
REQ-028 Package platform_pll_seq_pkg SHALL hold the state encodings and the loss_count width.
REQ-029 The synchronizer SHALL be sub-module platform_sync2 (1-bit, 2-flop, async active-low clear); the FSM and counters SHALL stay in one module.

Verification
All scenarios use RST_PULSE_CYCLES=4, LOCK_FILTER_CYCLES=8, LOCK_TIMEOUT_CYCLES=32 and MAX_RETRIES=2.
REQ-030 Nominal: release reset_n, raise pll_locked 10 cycles after pll_rst falls -> pll_rst high 4 cycles; sys_reset_n rises 2+8+1 cycles after pll_locked; seq_state=3.
REQ-031 Glitch filter: pll_locked high 5 cycles, low 1, then high -> no RUN until 8 consecutive synchronized-high cycles; seq_state returns to 1 once.
REQ-032 Timeout/fail: hold pll_locked=0 -> two 4-cycle pll_rst pulses separated by 32-cycle waits, then seq_state=4, fail=1, pll_rst=0; soft_reset_req -> fail=0, new pulse.
REQ-033 Loss of lock: in RUN, drop pll_locked -> sys_reset_n=0 3 cycles later, loss_count=1, pll_rst pulse of 4; repeat 300 times -> loss_count=255.
REQ-034 Simultaneous events: soft_reset_req on the same cycle the filter completes -> ASSERT_RST, not RUN.
REQ-035 Mid-sequence reset: assert reset_n low during FILTER -> outputs reach reset values with no clk edge; sequence restarts from ASSERT_RST.

Source files
------------

// File: rtl/platform_pll_seq_pkg.sv
// platform_pll_seq_pkg: shared state encoding and widths for the PLL reset sequencer
// Holds the sequencer state enum (encoding is visible on seq_state) and the loss counter width.
package platform_pll_seq_pkg;
  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_FILTER     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } seq_state_e;
  localparam int LOSS_W = 8;
endpackage

// File: rtl/platform_sync2.sv
// platform_sync2: 1-bit two-flop synchronizer with asynchronous active-low clear
// Ports: clk (destination clock), rst_n (async clear, active-low), d (async input), q (synchronized output)
module platform_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/platform_pll_reset_seq.sv
// platform_pll_reset_seq: PLL reset pulse, lock qualification and system reset release sequencer
// Ports: clk, reset_n (async active-low), pll_locked (async to clk), soft_reset_req (1-cycle restart);
//        pll_rst (active-high PLL reset), sys_reset_n (active-low system reset), seq_state (state code),
//        fail (lock never achieved), loss_count (saturating count of lock losses in RUN). All outputs registered.
module platform_pll_reset_seq
  import platform_pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_FILTER_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              soft_reset_req,
  output logic              pll_rst,
  output logic              sys_reset_n,
  output logic [2:0]        seq_state,
  output logic              fail,
  output logic [LOSS_W-1:0] loss_count
);
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);
  logic              locked_s;
  seq_state_e        state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [LOSS_W-1:0] loss_d;
  platform_sync2 u_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d    (pll_locked),
    .q    (locked_s)
  );
  // Every counter stops at its terminal value, so none can wrap; counters are
  // cleared on entry to the state that uses them.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    loss_d  = loss_count;
    if (soft_reset_req) begin
      state_d = ST_ASSERT_RST;
      pcnt_d  = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT_RST:
          if (pcnt_q == P_LAST) begin
            state_d = ST_WAIT_LOCK;
            tmr_d   = '0;
          end else pcnt_d = pcnt_q + 1'b1;
        ST_WAIT_LOCK:
          if (locked_s) begin
            state_d = ST_FILTER;
            fcnt_d  = '0;
          end else if (tmr_q == T_LAST) begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == R_MAX) ? ST_FAIL : ST_ASSERT_RST;
            pcnt_d  = '0;
          end else tmr_d = tmr_q + 1'b1;
        ST_FILTER:
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            tmr_d   = '0;
          end else if (fcnt_q == F_LAST) state_d = ST_RUN;
          else fcnt_d = fcnt_q + 1'b1;
        ST_RUN: begin
          retry_d = '0;
          if (!locked_s) begin
            state_d = ST_ASSERT_RST;
            pcnt_d  = '0;
            loss_d  = (&loss_count) ? loss_count : loss_count + 1'b1;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_ASSERT_RST;
      endcase
    end
  end
  // Outputs are registered from the next state so they change on the same edge as seq_state.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= ST_ASSERT_RST;
      pcnt_q      <= '0;
      fcnt_q      <= '0;
      tmr_q       <= '0;
      retry_q     <= '0;
      loss_count  <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      fcnt_q      <= fcnt_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      loss_count  <= loss_d;
      pll_rst     <= state_d == ST_ASSERT_RST;
      sys_reset_n <= state_d == ST_RUN;
      fail        <= state_d == ST_FAIL;
    end
  assign seq_state = state_q;
endmodule

// File: tb/tb_platform_pll_reset_seq.sv
// tb_platform_pll_reset_seq: directed and random checks of the PLL reset sequencer against a phase/age model
module tb_platform_pll_reset_seq;
  localparam int RP = 4, LF = 8, TO = 32, MR = 2;
  logic clk = 0, reset_n = 0, pll_locked = 0, soft_reset_req = 0;
  logic pll_rst, sys_reset_n, fail;
  logic [2:0] seq_state;
  logic [7:0] loss_count;
  int total = 0, bad = 0;
  int ph = 0, age = 0, tries = 0, loss = 0, prev_st = 0, refilter = 0, n = 0;
  bit hist[$];
  always #5 clk = ~clk;
  platform_pll_reset_seq #(
    .RST_PULSE_CYCLES(RP), .LOCK_FILTER_CYCLES(LF), .LOCK_TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .seq_state(seq_state), .fail(fail),
    .loss_count(loss_count)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  // Model: phase 0..4 plus the number of edges spent in the phase; lock is seen two edges late.
  task automatic model_reset();
    ph = 0; age = 0; tries = 0; loss = 0;
    hist.delete(); hist.push_back(0); hist.push_back(0);
  endtask
  task automatic go(int p);
    ph = p; age = 0;
  endtask
  task automatic model_step(bit lk, bit sr);
    bit ls;
    ls = hist.pop_front();
    hist.push_back(lk);
    age++;
    if (sr) begin tries = 0; go(0); end
    else if (ph == 0) begin if (age == RP) go(1); end
    else if (ph == 1) begin
      if (ls) go(2);
      else if (age == TO) begin tries++; go(tries == MR ? 4 : 0); end
    end
    else if (ph == 2) begin if (!ls) go(1); else if (age == LF) go(3); end
    else if (ph == 3) begin
      tries = 0;
      if (!ls) begin if (loss < 255) loss++; go(0); end
    end
  endtask
  task automatic check_all();
    chk("seq_state", seq_state, ph);
    chk("pll_rst", pll_rst, ph == 0);
    chk("sys_reset_n", sys_reset_n, ph == 3);
    chk("fail", fail, ph == 4);
    chk("loss_count", loss_count, loss);
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step(pll_locked, soft_reset_req);
    #1;
    check_all();
    if (prev_st == 2 && seq_state == 1) refilter++;
    prev_st = seq_state;
  endtask
  task automatic soft_pulse();
    soft_reset_req = 1; tick(); soft_reset_req = 0;
  endtask
  initial begin
    model_reset();
    tick(); tick();
    chk("reset_state", seq_state, 0);
    chk("reset_pll_rst", pll_rst, 1);
    // nominal bring-up
    reset_n = 1;
    n = 0; while (pll_rst && n < 50) begin tick(); n++; end
    chk("nom_pulse_len", n, RP);
    repeat (10) tick();
    pll_locked = 1;
    n = 0; while (!sys_reset_n && n < 100) begin tick(); n++; end
    chk("nom_lock_to_run", n, 2 + LF + 1);
    chk("nom_state_run", seq_state, 3);
    // glitch filter
    pll_locked = 0;
    soft_pulse();
    n = 0; while (seq_state != 1 && n < 50) begin tick(); n++; end
    refilter = 0;
    pll_locked = 1; repeat (5) tick();
    pll_locked = 0; tick();
    pll_locked = 1;
    n = 0; while (!sys_reset_n && n < 100) begin tick(); n++; end
    chk("glitch_reraise_to_run", n, 2 + LF + 1);
    chk("glitch_refilter_once", refilter, 1);
    // timeout and fail
    pll_locked = 0;
    soft_pulse();
    n = 0; while (pll_rst && n < 50) begin tick(); n++; end
    chk("to_pulse1", n, RP);
    n = 0; while (!pll_rst && seq_state != 4 && n < 100) begin tick(); n++; end
    chk("to_wait1", n, TO);
    n = 0; while (pll_rst && n < 50) begin tick(); n++; end
    chk("to_pulse2", n, RP);
    n = 0; while (!pll_rst && seq_state != 4 && n < 100) begin tick(); n++; end
    chk("to_wait2", n, TO);
    chk("to_fail_state", seq_state, 4);
    chk("to_fail_flag", fail, 1);
    chk("to_fail_pll_rst", pll_rst, 0);
    repeat (5) tick();
    chk("to_fail_sticky", fail, 1);
    soft_pulse();
    chk("to_soft_fail_clr", fail, 0);
    chk("to_soft_pll_rst", pll_rst, 1);
    // loss of lock, saturating counter
    pll_locked = 1;
    n = 0; while (!sys_reset_n && n < 100) begin tick(); n++; end
    for (int i = 0; i < 300; i++) begin
      pll_locked = 0;
      n = 0; while (sys_reset_n && n < 20) begin tick(); n++; end
      if (i == 0) begin
        chk("loss_latency", n, 3);
        chk("loss_count_1", loss_count, 1);
      end
      n = 0; while (pll_rst && n < 20) begin tick(); n++; end
      if (i == 0) chk("loss_pulse_len", n, RP);
      pll_locked = 1;
      n = 0; while (!sys_reset_n && n < 100) begin tick(); n++; end
      chk("loss_relock", sys_reset_n, 1);
    end
    chk("loss_saturated", loss_count, 255);
    // soft reset coinciding with filter completion
    pll_locked = 0;
    soft_pulse();
    repeat (RP) tick();
    chk("sim_in_wait", seq_state, 1);
    pll_locked = 1;
    repeat (2 + LF) tick();
    chk("sim_in_filter", seq_state, 2);
    soft_pulse();
    chk("sim_state_assert", seq_state, 0);
    chk("sim_no_release", sys_reset_n, 0);
    // asynchronous reset during FILTER
    n = 0; while (seq_state != 2 && n < 50) begin tick(); n++; end
    tick();
    #3 reset_n = 0;
    model_reset();
    #1;
    chk("async_state", seq_state, 0);
    chk("async_pll_rst", pll_rst, 1);
    chk("async_loss", loss_count, 0);
    check_all();
    tick();
    reset_n = 1;
    n = 0; while (pll_rst && n < 50) begin tick(); n++; end
    chk("async_restart_pulse", n, RP);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(i < 1500 ? 11 : 39) == 0) pll_locked = ~pll_locked;
      soft_reset_req = ($urandom_range(149) == 0);
      if ($urandom_range(699) == 0) begin
        reset_n = 0;
        model_reset();
        #1 check_all();
      end
      tick();
      reset_n = 1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
